// File: rtl/gbt_frame_checker.sv
// gbt_frame_checker: locks onto a GBT data stream whose frames carry a constant
// 52-bit header and an incrementing 32-bit counter, then counts checked and bad
// frames. Inputs are registered once and every output is registered, so a
// frame appears at the outputs two clock cycles after it is presented.
//
// Optional feature: define GBT_FRAME_CHECKER_ERRLOG_EN to capture the expected
// and received frames of the first bad frame after reset or clear_i. Without the
// macro, err_exp_ob84 and err_rcv_ob84 are tied to zero and no capture registers
// exist.

package gbt_frame_checker_pkg;

  // Clock and reset bundle; reset is active-low.
  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

endpackage

module gbt_frame_checker
  import gbt_frame_checker_pkg::*;
#(
  parameter logic [51:0] HEADER_B52    = 52'hc000babeac1da,
  parameter int          LOCK_COUNT    = 8,
  parameter int          UNLOCK_ERRORS = 4
) (
  input  ckrs_t        ClkRs_ix,
  input  logic         link_ready_i,
  input  logic         rx_isdata_i,
  input  logic [83:0]  rx_data_ib84,
  input  logic         clear_i,
  output logic         locked_o,
  output logic         frame_err_o,
  output logic [31:0]  err_cnt_ob32,
  output logic [31:0]  frame_cnt_ob32,
  output logic [1:0]   state_ob2,
  output logic [83:0]  err_exp_ob84,
  output logic [83:0]  err_rcv_ob84
);

  localparam logic [7:0] LOCK_CNT_C   = 8'(LOCK_COUNT);
  localparam logic [7:0] UNLOCK_ERR_C = 8'(UNLOCK_ERRORS);

  logic clk;
  logic rst_n_async;
  logic rst_n;

  assign clk         = ClkRs_ix.clk;
  assign rst_n_async = ClkRs_ix.reset;

  // Reset synchronizer: assertion passes straight through, release waits two clocks.
  // NOTE: the async clear lets reset take effect with no clock running, while the
  // two-flop release keeps every flop leaving reset on the same clock edge.
  logic [1:0] rst_sync_q;
  always_ff @(posedge clk or negedge rst_n_async) begin
    if (!rst_n_async) rst_sync_q <= 2'b00;
    else              rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // Input stage: register every input once.
  logic        link_q;
  logic        isdata_q;
  logic [83:0] data_q;
  logic        clear_q;

  // Input register bank.
  // NOTE: flops are always written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_q   <= 1'b0;
      isdata_q <= 1'b0;
      data_q   <= '0;
      clear_q  <= 1'b0;
    end else begin
      link_q   <= link_ready_i;
      isdata_q <= rx_isdata_i;
      data_q   <= rx_data_ib84;
      clear_q  <= clear_i;
    end
  end

  // Checker state and registered outputs.
  state_e      state_q,     state_d;
  logic [7:0]  run_cnt_q,   run_cnt_d;
  logic [7:0]  err_run_q,   err_run_d;
  logic [31:0] exp_cnt_q,   exp_cnt_d;
  logic        locked_q,    locked_d;
  logic        frame_err_q, frame_err_d;
  logic [31:0] err_cnt_q,   err_cnt_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;

  logic        header_ok;
  logic        count_ok;
  logic        err_inc;
  logic        frame_inc;
  logic [7:0]  run_cnt_inc;
  logic [7:0]  err_run_inc;

  assign header_ok   = (data_q[83:32] == HEADER_B52);
  assign count_ok    = (data_q[31:0] == exp_cnt_q);
  assign run_cnt_inc = run_cnt_q + 8'd1;
  assign err_run_inc = err_run_q + 8'd1;

  // Next-state logic: link supervision, hunting, lock tracking and statistics.
  // NOTE: every variable gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    err_run_d   = err_run_q;
    exp_cnt_d   = exp_cnt_q;
    frame_err_d = 1'b0;
    err_inc     = 1'b0;
    frame_inc   = 1'b0;

    if (!link_q) begin
      state_d   = ST_IDLE;
      run_cnt_d = 8'd0;
      err_run_d = 8'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d   = ST_HUNT;
          run_cnt_d = 8'd0;
          err_run_d = 8'd0;
        end
        ST_HUNT: begin
          if (isdata_q) begin
            if (header_ok) begin
              exp_cnt_d = data_q[31:0] + 32'd1;
              run_cnt_d = run_cnt_inc;
              if (run_cnt_inc == LOCK_CNT_C) begin
                state_d   = ST_LOCKED;
                err_run_d = 8'd0;
              end
            end else begin
              run_cnt_d = 8'd0;
            end
          end
        end
        ST_LOCKED: begin
          if (isdata_q) begin
            frame_inc = 1'b1;
            if (header_ok && count_ok) begin
              exp_cnt_d = exp_cnt_q + 32'd1;
              err_run_d = 8'd0;
            end else begin
              frame_err_d = 1'b1;
              err_inc     = 1'b1;
              exp_cnt_d   = data_q[31:0] + 32'd1;
              err_run_d   = err_run_inc;
              if (err_run_inc == UNLOCK_ERR_C) begin
                state_d   = ST_HUNT;
                run_cnt_d = 8'd0;
                err_run_d = 8'd0;
              end
            end
          end
        end
        default: begin
          state_d   = ST_IDLE;
          run_cnt_d = 8'd0;
          err_run_d = 8'd0;
        end
      endcase
    end

    // Statistics: saturating, and a same-cycle clear beats an increment.
    if (clear_q)                        frame_cnt_d = 32'd0;
    else if (frame_inc && !(&frame_cnt_q)) frame_cnt_d = frame_cnt_q + 32'd1;
    else                                frame_cnt_d = frame_cnt_q;

    if (clear_q)                        err_cnt_d = 32'd0;
    else if (err_inc && !(&err_cnt_q))  err_cnt_d = err_cnt_q + 32'd1;
    else                                err_cnt_d = err_cnt_q;

    locked_d = (state_d == ST_LOCKED);
  end

  // Checker FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      run_cnt_q   <= 8'd0;
      err_run_q   <= 8'd0;
      exp_cnt_q   <= 32'd0;
      locked_q    <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= 32'd0;
      frame_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      err_run_q   <= err_run_d;
      exp_cnt_q   <= exp_cnt_d;
      locked_q    <= locked_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign locked_o       = locked_q;
  assign frame_err_o    = frame_err_q;
  assign err_cnt_ob32   = err_cnt_q;
  assign frame_cnt_ob32 = frame_cnt_q;
  assign state_ob2      = state_q;

`ifdef GBT_FRAME_CHECKER_ERRLOG_EN
  logic        logged_q,  logged_d;
  logic [83:0] err_exp_q, err_exp_d;
  logic [83:0] err_rcv_q, err_rcv_d;

  // First-error capture; armed again only by clear_i.
  always_comb begin
    logged_d  = logged_q;
    err_exp_d = err_exp_q;
    err_rcv_d = err_rcv_q;
    if (clear_q) begin
      logged_d  = 1'b0;
      err_exp_d = '0;
      err_rcv_d = '0;
    end else if (err_inc && !logged_q) begin
      logged_d  = 1'b1;
      err_exp_d = {HEADER_B52, exp_cnt_q};
      err_rcv_d = data_q;
    end
  end

  // Error-log registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      logged_q  <= 1'b0;
      err_exp_q <= '0;
      err_rcv_q <= '0;
    end else begin
      logged_q  <= logged_d;
      err_exp_q <= err_exp_d;
      err_rcv_q <= err_rcv_d;
    end
  end

  assign err_exp_ob84 = err_exp_q;
  assign err_rcv_ob84 = err_rcv_q;
`else
  assign err_exp_ob84 = '0;
  assign err_rcv_ob84 = '0;
`endif

endmodule

// File: tb/tb_gbt_frame_checker.sv
// tb_gbt_frame_checker: directed bench for gbt_frame_checker. A table of single
// frames (each followed by one ignored cycle) covers locking and error counting;
// hand-written sequences cover wrap-around, unlock/relock, isdata gaps, clear,
// link drop and asynchronous reset. Error-log expectations follow
// GBT_FRAME_CHECKER_ERRLOG_EN.
`timescale 1ns/1ps

module tb_gbt_frame_checker;
  import gbt_frame_checker_pkg::*;

  localparam logic [51:0] HDR     = 52'hc000babeac1da;
  localparam logic [51:0] BAD_HDR = 52'hc000babeac1db;

  logic         clk = 1'b0;
  logic         rst_n;
  ckrs_t        clk_rs;
  logic         link_ready;
  logic         rx_isdata;
  logic [83:0]  rx_data;
  logic         clear;
  logic         locked;
  logic         frame_err;
  logic [31:0]  err_cnt;
  logic [31:0]  frame_cnt;
  logic [1:0]   state;
  logic [83:0]  err_exp;
  logic [83:0]  err_rcv;

  int tests = 0;
  int fails = 0;
  int pulse_cnt = 0;

  assign clk_rs = '{clk: clk, reset: rst_n};

  always #10 clk = ~clk;

  gbt_frame_checker dut (
    .ClkRs_ix       (clk_rs),
    .link_ready_i   (link_ready),
    .rx_isdata_i    (rx_isdata),
    .rx_data_ib84   (rx_data),
    .clear_i        (clear),
    .locked_o       (locked),
    .frame_err_o    (frame_err),
    .err_cnt_ob32   (err_cnt),
    .frame_cnt_ob32 (frame_cnt),
    .state_ob2      (state),
    .err_exp_ob84   (err_exp),
    .err_rcv_ob84   (err_rcv)
  );

  typedef struct {
    logic        isdata;
    logic [83:0] data;
    logic [1:0]  st;
    logic        lk;
    logic        fe;
    logic [31:0] ec;
    logic [31:0] fc;
  } vec_t;

  vec_t vecs[18];

  function automatic logic [83:0] frm(input logic [31:0] c);
    return {HDR, c};
  endfunction

  function automatic vec_t mkv(input logic isd, input logic [83:0] d, input logic [1:0] st,
                               input logic lk, input logic fe, input logic [31:0] ec,
                               input logic [31:0] fc);
    vec_t v;
    v.isdata = isd; v.data = d; v.st = st; v.lk = lk; v.fe = fe; v.ec = ec; v.fc = fc;
    return v;
  endfunction

  task automatic check(input string name, input logic [83:0] act, input logic [83:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock; outputs are sampled 1 ns after the edge and error pulses counted.
  task automatic tick();
    @(posedge clk);
    #1;
    if (frame_err === 1'b1) pulse_cnt++;
  endtask

  task automatic drive(input logic lr, input logic isd, input logic [83:0] d, input logic clr);
    link_ready = lr;
    rx_isdata  = isd;
    rx_data    = d;
    clear      = clr;
  endtask

  task automatic stream(input logic [83:0] d);
    drive(1'b1, 1'b1, d, 1'b0);
    tick();
  endtask

  task automatic flush();
    drive(1'b1, 1'b0, '0, 1'b0);
    tick();
    tick();
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic link_up();
    drive(1'b1, 1'b0, '0, 1'b0);
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [83:0] bit40;
    logic [83:0] exp_log;
    bit40 = 84'd1 << 40;

    // Table: lock on frames 0..7, then locked-state checks.
    for (int i = 0; i < 7; i++) vecs[i] = mkv(1'b1, frm(32'(i)), 2'd1, 1'b0, 1'b0, 32'd0, 32'd0);
    vecs[7]  = mkv(1'b1, frm(32'd7),         2'd2, 1'b1, 1'b0, 32'd0, 32'd0);
    vecs[8]  = mkv(1'b1, frm(32'd8),         2'd2, 1'b1, 1'b0, 32'd0, 32'd1);
    vecs[9]  = mkv(1'b1, frm(32'd9),         2'd2, 1'b1, 1'b0, 32'd0, 32'd2);
    vecs[10] = mkv(1'b1, frm(32'd10) ^ bit40, 2'd2, 1'b1, 1'b1, 32'd1, 32'd3);
    vecs[11] = mkv(1'b1, frm(32'd11),        2'd2, 1'b1, 1'b0, 32'd1, 32'd4);
    vecs[12] = mkv(1'b1, frm(32'd20),        2'd2, 1'b1, 1'b1, 32'd2, 32'd5);
    vecs[13] = mkv(1'b1, frm(32'd21),        2'd2, 1'b1, 1'b0, 32'd2, 32'd6);
    vecs[14] = mkv(1'b0, frm(32'd22),        2'd2, 1'b1, 1'b0, 32'd2, 32'd6);
    vecs[15] = mkv(1'b1, frm(32'd22),        2'd2, 1'b1, 1'b0, 32'd2, 32'd7);
    vecs[16] = mkv(1'b1, {BAD_HDR, 32'd23},  2'd2, 1'b1, 1'b1, 32'd3, 32'd8);
    vecs[17] = mkv(1'b1, frm(32'd24),        2'd2, 1'b1, 1'b0, 32'd3, 32'd9);

    // Reset state, sampled while reset is held.
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);
    tick();
    tick();
    check("rst_state",     state,     2'd0);
    check("rst_locked",    locked,    1'b0);
    check("rst_err_cnt",   err_cnt,   32'd0);
    check("rst_frame_cnt", frame_cnt, 32'd0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_err_exp",   err_exp,   84'd0);
    check("rst_err_rcv",   err_rcv,   84'd0);
    rst_n = 1'b1;
    repeat (4) tick();
    check("idle_no_link", state, 2'd0);

    // IDLE -> HUNT two cycles after link_ready rises.
    drive(1'b1, 1'b0, '0, 1'b0);
    tick();
    check("idle_hold_lat1", state, 2'd0);
    tick();
    check("idle_to_hunt", state, 2'd1);

    for (int i = 0; i < 18; i++) begin
      drive(1'b1, vecs[i].isdata, vecs[i].data, 1'b0);
      tick();
      drive(1'b1, 1'b0, '0, 1'b0);
      tick();
      check($sformatf("v%0d_state", i),     state,     vecs[i].st);
      check($sformatf("v%0d_locked", i),    locked,    vecs[i].lk);
      check($sformatf("v%0d_frame_err", i), frame_err, vecs[i].fe);
      check($sformatf("v%0d_err_cnt", i),   err_cnt,   vecs[i].ec);
      check($sformatf("v%0d_frame_cnt", i), frame_cnt, vecs[i].fc);
    end

`ifdef GBT_FRAME_CHECKER_ERRLOG_EN
    check("log1_exp", err_exp, frm(32'd10));
    check("log1_rcv", err_rcv, frm(32'd10) ^ bit40);
`else
    check("log1_exp", err_exp, 84'd0);
    check("log1_rcv", err_rcv, 84'd0);
`endif

    // Wrap-around: lock just below 2^32, then run through the wrap.
    do_reset();
    link_up();
    for (int i = 0; i < 8; i++) stream(frm(32'hfffffff6 + 32'(i)));
    drive(1'b1, 1'b0, '0, 1'b0);
    check("lock_lat1", locked, 1'b0);
    tick();
    check("lock_lat2", locked, 1'b1);
    pulse_cnt = 0;
    stream(frm(32'hfffffffe));
    stream(frm(32'hffffffff));
    stream(frm(32'h00000000));
    stream(frm(32'h00000001));
    flush();
    check("wrap_pulses",    pulse_cnt, 0);
    check("wrap_frame_cnt", frame_cnt, 32'd4);
    check("wrap_err_cnt",   err_cnt,   32'd0);

    // Unlock after four consecutive bad headers, then relock.
    pulse_cnt = 0;
    for (int i = 0; i < 4; i++) stream({BAD_HDR, 32'd2 + 32'(i)});
    flush();
    check("unlock_pulses",    pulse_cnt, 4);
    check("unlock_state",     state,     2'd1);
    check("unlock_locked",    locked,    1'b0);
    check("unlock_err_cnt",   err_cnt,   32'd4);
    check("unlock_frame_cnt", frame_cnt, 32'd8);
`ifdef GBT_FRAME_CHECKER_ERRLOG_EN
    check("log2_exp", err_exp, frm(32'd2));
    check("log2_rcv", err_rcv, {BAD_HDR, 32'd2});
`else
    check("log2_exp", err_exp, 84'd0);
`endif
    for (int i = 0; i < 8; i++) stream(frm(32'd100 + 32'(i)));
    flush();
    check("relock_state",  state,  2'd2);
    check("relock_locked", locked, 1'b1);

    // isdata gap with garbage data, then resume the counter.
    pulse_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, {$urandom, $urandom, $urandom}, 1'b0);
      tick();
    end
    stream(frm(32'd108));
    stream(frm(32'd109));
    flush();
    check("gap_pulses",    pulse_cnt, 0);
    check("gap_err_cnt",   err_cnt,   32'd4);
    check("gap_frame_cnt", frame_cnt, 32'd10);

    // clear_i together with a bad frame: clear wins.
    drive(1'b1, 1'b1, frm(32'd500), 1'b1);
    tick();
    flush();
    check("clear_err_cnt",   err_cnt,   32'd0);
    check("clear_frame_cnt", frame_cnt, 32'd0);
    check("clear_err_exp",   err_exp,   84'd0);
    check("clear_err_rcv",   err_rcv,   84'd0);
    stream(frm(32'd700));
    flush();
    check("post_clear_err_cnt",   err_cnt,   32'd1);
    check("post_clear_frame_cnt", frame_cnt, 32'd1);
`ifdef GBT_FRAME_CHECKER_ERRLOG_EN
    exp_log = frm(32'd501);
    check("log3_exp", err_exp, exp_log);
    check("log3_rcv", err_rcv, frm(32'd700));
`else
    exp_log = '0;
    check("log3_exp", err_exp, exp_log);
`endif
    stream(frm(32'd701));
    flush();
    check("resync_frame_cnt", frame_cnt, 32'd2);
    check("resync_err_cnt",   err_cnt,   32'd1);

    // Link drop: IDLE two cycles later, statistics held.
    drive(1'b0, 1'b0, '0, 1'b0);
    tick();
    check("drop_lat1_state", state, 2'd2);
    tick();
    check("drop_state",     state,     2'd0);
    check("drop_locked",    locked,    1'b0);
    check("drop_err_cnt",   err_cnt,   32'd1);
    check("drop_frame_cnt", frame_cnt, 32'd2);

    // Relock, then assert reset mid-frame: outputs clear without a clock edge.
    link_up();
    for (int i = 0; i < 8; i++) stream(frm(32'd50 + 32'(i)));
    flush();
    check("relock2_locked", locked, 1'b1);
    drive(1'b1, 1'b1, frm(32'd58), 1'b0);
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    check("arst_locked",    locked,    1'b0);
    check("arst_state",     state,     2'd0);
    check("arst_err_cnt",   err_cnt,   32'd0);
    check("arst_frame_cnt", frame_cnt, 32'd0);
    check("arst_frame_err", frame_err, 1'b0);
    check("arst_err_exp",   err_exp,   84'd0);
    check("arst_err_rcv",   err_rcv,   84'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gbt_frame_checker.md
GBT_FRAME_CHECKER -- requirements
Module: gbt_frame_checker

Interface
REQ-001 SHALL have parameter HEADER_B52, default 52'hc000babeac1da, the constant upper 52 bits of every valid frame.
REQ-002 SHALL have parameter LOCK_COUNT, default 8, the number of consecutive correct frames needed to lock (range 1..255).
REQ-003 SHALL have parameter UNLOCK_ERRORS, default 4, the number of consecutive bad frames that drops lock (range 1..255).
REQ-004 SHALL have port ClkRs_ix, input, ckrs_t, carrying the 40 MHz frame clock ClkRs_ix.clk and the reset ClkRs_ix.reset; the design uses one clock, and the reset is asynchronous and active-low.
REQ-005 SHALL have port link_ready_i, input, width 1: GBT link ready.
REQ-006 SHALL have port rx_isdata_i, input, width 1: the frame is a data frame and is checked only when this is 1.
REQ-007 SHALL have port rx_data_ib84, input, width 84: received GBT frame.
REQ-008 SHALL have port clear_i, input, width 1: synchronous clear of the statistics counters.
REQ-009 SHALL have port locked_o, output, width 1: checker is locked to the stream.
REQ-010 SHALL have port frame_err_o, output, width 1: one-cycle pulse for each bad frame while LOCKED.
REQ-011 SHALL have port err_cnt_ob32, output, width 32: saturating count of bad frames.
REQ-012 SHALL have port frame_cnt_ob32, output, width 32: saturating count of checked frames.
REQ-013 SHALL have port state_ob2, output, width 2: FSM state, encoded IDLE=0, HUNT=1, LOCKED=2.
REQ-014 SHALL have ports err_exp_ob84 and err_rcv_ob84, outputs, width 84: the expected frame and the received frame of the first error (see Configuration).

Function
REQ-015 SHALL register all inputs once; every output SHALL be registered, so the total input-to-output latency is 2 cycles.
REQ-016 SHALL define a frame as correct when data[83:32]==HEADER_B52 and data[31:0]==expected counter.
REQ-017 SHALL stay in IDLE while link_ready_i=0 and SHALL move to HUNT on the first cycle link_ready_i=1.
REQ-018 SHALL return to IDLE from any state in the cycle after link_ready_i falls; the lock/run counters SHALL clear, and the statistics counters SHALL be held.
REQ-019 HUNT, header match: expected counter SHALL load data[31:0]+1 and the run counter SHALL increment.
REQ-020 HUNT, header mismatch: the run counter SHALL reset to 0.
REQ-021 HUNT: when the run counter reaches LOCK_COUNT, the FSM SHALL move to LOCKED.
REQ-022 LOCKED: each checked frame SHALL increment frame_cnt, and the expected counter SHALL advance by 1 modulo 2^32, so 32'hffffffff is followed by 0 with no error.
REQ-023 LOCKED, bad frame: the FSM SHALL pulse frame_err_o, increment err_cnt and the consecutive-error counter, and resync the expected counter to the received value+1.
REQ-024 LOCKED, correct frame: the consecutive-error counter SHALL clear.
REQ-025 When the consecutive-error counter reaches UNLOCK_ERRORS, the FSM SHALL move to HUNT with the run counter at 0.
REQ-026 Frames with rx_isdata_i=0 SHALL be ignored: no counters change and the expected counter does not advance.
REQ-027 err_cnt and frame_cnt SHALL saturate at 32'hffffffff.
REQ-028 clear_i SHALL zero both statistics counters; if clear_i and an increment occur in the same cycle, the counter SHALL become 0.
REQ-029 locked_o SHALL be 1 exactly when state_ob2 is LOCKED.

Reset
REQ-030 While ClkRs_ix.reset=0 the design SHALL be in IDLE, and every output and counter SHALL be 0.
REQ-031 Reset SHALL act asynchronously on assertion and be released synchronously to ClkRs_ix.clk; reset during LOCKED SHALL drop locked_o immediately.

Configuration
REQ-032 When macro GBT_FRAME_CHECKER_ERRLOG_EN is defined, the first bad frame after reset or clear_i SHALL capture the expected frame into err_exp_ob84 and the received frame into err_rcv_ob84; later errors SHALL NOT overwrite them until clear_i.
REQ-033 When the macro is undefined, err_exp_ob84 and err_rcv_ob84 SHALL be tied to 0, the ports SHALL remain present, and no capture registers SHALL be inferred.

Verification
REQ-034 Directed test, basic lock: link_ready=1, counter frames from 32'h0 with header c000babeac1da -> locked_o=1 after the 8th frame+2 cycles, err_cnt=0.
REQ-035 Directed test, wrap-around: lock, then send 32'hfffffffe, ffffffff, 0, 1 -> no frame_err_o, frame_cnt advances by 4.
REQ-036 Directed test, single error: lock, then one frame with bit 40 flipped -> one frame_err_o pulse, err_cnt=1, locked_o stays 1; with ERRLOG_EN, err_rcv_ob84 holds the corrupt frame.
REQ-037 Directed test, unlock: lock, then 4 consecutive bad-header frames -> state HUNT, locked_o=0, err_cnt=4; 8 good frames -> relock.
REQ-038 Directed test, isdata gap and clear: lock, hold rx_isdata_i=0 for 5 cycles, then resume the counter -> no error; assert clear_i together with an error -> err_cnt=0.
REQ-039 Directed test, link drop and reset: in LOCKED, drop link_ready -> IDLE with counters held; assert reset mid-frame -> all outputs 0 immediately.
